mc_scoreboard: RTL and testbench

- Producer-side hazard tracker for multi-cycle units (int div, fdiv, fsqrt, R4 FMA) in the rv32imf core.
- Records destination registers when an op issues from EXE. Clears them when the unit writes back.
- Stalls ID when any source operand, or a WAW destination, is still pending. Also reserves writeback-port slots for fixed-latency ops.
- Complements the forwarding unit: the scoreboard decides when a value does not yet exist, and forwarding supplies the value once it reaches WB.

---
 rtl/mc_scoreboard_pkg.sv | 15 +
 rtl/mc_sb_pend_vec.sv | 31 +++
 rtl/mc_scoreboard.sv | 74 +++++++
 tb/tb_mc_scoreboard.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_scoreboard_pkg.sv
// mc_scoreboard_pkg: shared types and constants for the multi-cycle hazard scoreboard.
package mc_scoreboard_pkg;
  localparam int NUM_REGS = 32;
  localparam logic [4:0] X0 = 5'd0;
  localparam int SB_LAT_W = 4;
  typedef enum logic {RF_INT, RF_FP} rf_sel_e;
  typedef struct packed {
    logic [4:0]          rd;
    rf_sel_e             rf;
    logic [SB_LAT_W-1:0] latency;
  } sb_issue_t;
  function automatic logic [NUM_REGS-1:0] onehot(input logic [4:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction
endpackage

// File: rtl/mc_sb_pend_vec.sv
// mc_sb_pend_vec: per-register pending bits with set/clear, lookups that
// hide a same-cycle clear, and issue-over-clear priority.
module mc_sb_pend_vec
  import mc_scoreboard_pkg::*;
#(
  parameter bit MASK_X0 = 1'b0,
  parameter int N_LK    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_set_en,
  input  logic [4:0]          i_set_idx,
  input  logic                i_clr_en,
  input  logic [4:0]          i_clr_idx,
  input  logic [N_LK-1:0][4:0] i_lk_idx,
  output logic [N_LK-1:0]     o_lk_hit,
  output logic                o_clr_err
);
  logic [NUM_REGS-1:0] r_pend, w_set, w_clr, w_live;
  assign w_set = (i_set_en && !(MASK_X0 && i_set_idx == X0)) ? onehot(i_set_idx) : '0;
  assign w_clr = i_clr_en ? onehot(i_clr_idx) : '0;
  // A register written back this cycle is supplied by forwarding, so it is no longer live
  assign w_live = r_pend & ~w_clr;
  assign o_clr_err = i_clr_en && !r_pend[i_clr_idx] && !(MASK_X0 && i_clr_idx == X0);
  for (genvar g = 0; g < N_LK; g++) begin : g_lk
    assign o_lk_hit[g] = w_live[i_lk_idx[g]];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_pend <= '0;
    else          r_pend <= w_live | w_set;
endmodule

// File: rtl/mc_scoreboard.sv
// mc_scoreboard: tracks destinations of in-flight multi-cycle ops, stalls dependent
// ID ops and arbitrates writeback slots for fixed-latency issues.
module mc_scoreboard
  import mc_scoreboard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int WB_DEPTH        = 8,
  parameter int LAT_W           = SB_LAT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic             issue_is_fp,
  input  logic [LAT_W-1:0] issue_latency,
  input  logic             cmpl_valid,
  input  logic [4:0]       cmpl_rd,
  input  logic             cmpl_is_fp,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rs3_id,
  input  logic             rs1_fp_id,
  input  logic             rs2_fp_id,
  input  logic             rs3_used_id,
  input  logic [4:0]       rd_id,
  input  logic             rd_fp_id,
  input  logic             rd_wr_id,
  output logic             hazard_stall,
  output logic             issue_stall,
  output logic             busy,
  output logic             sb_error
);
  sb_issue_t           w_iss;
  logic [3:0]          r_out_cnt;
  logic [WB_DEPTH-1:0] r_wb_slot, w_slot_shift, w_lat_mask;
  logic                r_err, w_accept, w_dec, w_int_err, w_fp_err;
  logic [2:0]          w_int_hit;
  logic [3:0]          w_fp_hit;
  assign w_iss = '{rd: issue_rd, rf: issue_is_fp ? RF_FP : RF_INT, latency: SB_LAT_W'(issue_latency)};
  assign w_lat_mask = (w_iss.latency == '0) ? '0 : WB_DEPTH'(1) << (w_iss.latency - 1'b1);
  // Collision is judged against the slot map as it will look next cycle, where the new reservation lands
  assign w_slot_shift = r_wb_slot >> 1;
  assign issue_stall = ((r_out_cnt == 4'(MAX_OUTSTANDING)) && !cmpl_valid) || |(w_slot_shift & w_lat_mask);
  assign w_accept = issue_valid && !issue_stall;
  assign w_dec = cmpl_valid && r_out_cnt != '0;
  mc_sb_pend_vec #(.MASK_X0(1'b1), .N_LK(3)) u_int (
    .clk(clk), .reset_n(reset_n),
    .i_set_en(w_accept && w_iss.rf == RF_INT), .i_set_idx(w_iss.rd),
    .i_clr_en(cmpl_valid && !cmpl_is_fp), .i_clr_idx(cmpl_rd),
    .i_lk_idx({rd_id, rs2_id, rs1_id}), .o_lk_hit(w_int_hit), .o_clr_err(w_int_err)
  );
  mc_sb_pend_vec #(.MASK_X0(1'b0), .N_LK(4)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .i_set_en(w_accept && w_iss.rf == RF_FP), .i_set_idx(w_iss.rd),
    .i_clr_en(cmpl_valid && cmpl_is_fp), .i_clr_idx(cmpl_rd),
    .i_lk_idx({rs3_id, rd_id, rs2_id, rs1_id}), .o_lk_hit(w_fp_hit), .o_clr_err(w_fp_err)
  );
  assign hazard_stall = (rs1_fp_id ? w_fp_hit[0] : w_int_hit[0]) ||
                        (rs2_fp_id ? w_fp_hit[1] : w_int_hit[1]) ||
                        (rs3_used_id && w_fp_hit[3]) ||
                        (rd_wr_id && (rd_fp_id ? w_fp_hit[2] : w_int_hit[2]));
  assign busy = r_out_cnt != '0;
  assign sb_error = r_err;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_out_cnt <= '0;
      r_wb_slot <= '0;
      r_err     <= 1'b0;
    end else begin
      r_out_cnt <= r_out_cnt + {3'd0, w_accept} - {3'd0, w_dec};
      r_wb_slot <= w_slot_shift | (w_accept ? w_lat_mask : '0);
      r_err     <= r_err || w_int_err || w_fp_err;
    end
endmodule

// File: tb/tb_mc_scoreboard.sv
// tb_mc_scoreboard: directed scenarios plus randomized traffic checked against
// a register-set / writeback-calendar reference model.
module tb_mc_scoreboard;
  logic clk = 1'b0;
  logic reset_n;
  logic issue_valid, issue_is_fp, cmpl_valid, cmpl_is_fp;
  logic [4:0] issue_rd, cmpl_rd, rs1_id, rs2_id, rs3_id, rd_id;
  logic [3:0] issue_latency;
  logic rs1_fp_id, rs2_fp_id, rs3_used_id, rd_fp_id, rd_wr_id;
  logic hazard_stall, issue_stall, busy, sb_error;
  int checks = 0;
  int errors = 0;

  bit m_int[32];
  bit m_fp[32];
  int m_cnt;
  bit m_err;
  bit m_resv[int];
  int m_cyc = 0;

  always #5 clk = ~clk;

  mc_scoreboard dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_fp(issue_is_fp), .issue_latency(issue_latency),
    .cmpl_valid(cmpl_valid), .cmpl_rd(cmpl_rd), .cmpl_is_fp(cmpl_is_fp),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs3_id(rs3_id),
    .rs1_fp_id(rs1_fp_id), .rs2_fp_id(rs2_fp_id), .rs3_used_id(rs3_used_id),
    .rd_id(rd_id), .rd_fp_id(rd_fp_id), .rd_wr_id(rd_wr_id),
    .hazard_stall(hazard_stall), .issue_stall(issue_stall), .busy(busy), .sb_error(sb_error)
  );

  function automatic void m_clear();
    foreach (m_int[i]) begin
      m_int[i] = 0;
      m_fp[i] = 0;
    end
    m_cnt = 0;
    m_err = 0;
    m_resv.delete();
  endfunction

  function automatic bit m_vis(input bit fp, input logic [4:0] r);
    if (!fp && r == 0) return 0;
    if (cmpl_valid && cmpl_is_fp == fp && cmpl_rd == r) return 0;
    return fp ? m_fp[r] : m_int[r];
  endfunction

  function automatic bit exp_istall();
    int l = int'(issue_latency);
    bit coll = l != 0 && l <= 8 && m_resv.exists(m_cyc + l);
    return (m_cnt == 4 && !cmpl_valid) || coll;
  endfunction

  function automatic bit exp_hazard();
    return m_vis(rs1_fp_id, rs1_id) || m_vis(rs2_fp_id, rs2_id) ||
           (rs3_used_id && m_vis(1'b1, rs3_id)) || (rd_wr_id && m_vis(rd_fp_id, rd_id));
  endfunction

  task automatic tick();
    bit acc;
    int dec;
    int l;
    acc = issue_valid && !exp_istall();
    dec = (cmpl_valid && m_cnt > 0) ? 1 : 0;
    if (cmpl_valid) begin
      if (cmpl_is_fp) begin
        if (!m_fp[cmpl_rd]) m_err = 1;
        m_fp[cmpl_rd] = 0;
      end else if (cmpl_rd != 0) begin
        if (!m_int[cmpl_rd]) m_err = 1;
        m_int[cmpl_rd] = 0;
      end
    end
    if (acc) begin
      if (issue_is_fp) m_fp[issue_rd] = 1;
      else if (issue_rd != 0) m_int[issue_rd] = 1;
      l = int'(issue_latency);
      if (l >= 1 && l <= 8) m_resv[m_cyc + l] = 1;
    end
    m_cnt = m_cnt + int'(acc) - dec;
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = 0; issue_is_fp = 0; issue_latency = 0;
    cmpl_valid = 0; cmpl_rd = 0; cmpl_is_fp = 0;
    rs1_id = 0; rs2_id = 0; rs3_id = 0; rd_id = 0;
    rs1_fp_id = 0; rs2_fp_id = 0; rs3_used_id = 0; rd_fp_id = 0; rd_wr_id = 0;
  endtask

  task automatic set_issue(input logic [4:0] rd, input bit fp, input logic [3:0] lat);
    issue_valid = 1; issue_rd = rd; issue_is_fp = fp; issue_latency = lat;
  endtask

  task automatic set_cmpl(input logic [4:0] rd, input bit fp);
    cmpl_valid = 1; cmpl_rd = rd; cmpl_is_fp = fp;
  endtask

  task automatic set_id(input logic [4:0] r1, input bit f1, input logic [4:0] r2, input bit f2,
                        input logic [4:0] rd, input bit fd, input bit wr);
    rs1_id = r1; rs1_fp_id = f1; rs2_id = r2; rs2_fp_id = f2; rd_id = rd; rd_fp_id = fd; rd_wr_id = wr;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (hazard_stall !== 1'b0) begin errors++; $display("FAIL reset_hazard got %0b want 0", hazard_stall); end
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL reset_issue_stall got %0b want 0", issue_stall); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    if (sb_error !== 1'b0) begin errors++; $display("FAIL reset_sb_error got %0b want 0", sb_error); end
    m_clear();
    reset_n = 1;
    tick();
  endtask

  task automatic test_raw();
    idle();
    set_issue(5, 1, 0);
    #1;
    checks++;
    if (issue_stall !== exp_istall()) begin errors++; $display("FAIL raw_issue got %0b want %0b", issue_stall, exp_istall()); end
    tick();
    idle();
    repeat (3) tick();
    set_id(5, 1, 2, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (hazard_stall !== 1'b1 || exp_hazard() !== 1'b1) begin
        errors++; $display("FAIL raw_stall got %0b want 1", hazard_stall);
      end
      tick();
    end
    set_cmpl(5, 1);
    #1;
    checks += 2;
    if (hazard_stall !== exp_hazard()) begin errors++; $display("FAIL raw_cmpl_cycle got %0b want %0b", hazard_stall, exp_hazard()); end
    if (busy !== 1'b1) begin errors++; $display("FAIL raw_busy_hold got %0b want 1", busy); end
    tick();
    idle();
    #1;
    checks++;
    if (busy !== (m_cnt != 0)) begin errors++; $display("FAIL raw_busy_fall got %0b want %0b", busy, m_cnt != 0); end
  endtask

  task automatic test_file_sep();
    idle();
    set_issue(5, 0, 0);
    tick();
    idle();
    set_id(5, 1, 2, 1, 1, 1, 1);
    #1;
    checks++;
    if (hazard_stall !== exp_hazard()) begin errors++; $display("FAIL filesep_fp got %0b want %0b", hazard_stall, exp_hazard()); end
    set_id(5, 0, 2, 0, 1, 0, 1);
    #1;
    checks++;
    if (hazard_stall !== exp_hazard()) begin errors++; $display("FAIL filesep_int got %0b want %0b", hazard_stall, exp_hazard()); end
    idle();
    set_cmpl(5, 0);
    tick();
    idle();
  endtask

  task automatic test_capacity();
    idle();
    for (int i = 1; i <= 4; i++) begin
      set_issue(5'(i), 0, 0);
      #1;
      checks++;
      if (issue_stall !== exp_istall()) begin errors++; $display("FAIL cap_fill%0d got %0b want %0b", i, issue_stall, exp_istall()); end
      tick();
    end
    set_issue(6, 0, 0);
    set_id(1, 0, 0, 0, 0, 0, 0);
    #1;
    checks += 2;
    if (issue_stall !== exp_istall()) begin errors++; $display("FAIL cap_full got %0b want %0b", issue_stall, exp_istall()); end
    if (hazard_stall !== exp_hazard()) begin errors++; $display("FAIL cap_hazard got %0b want %0b", hazard_stall, exp_hazard()); end
    set_cmpl(1, 0);
    #1;
    checks += 2;
    if (issue_stall !== exp_istall()) begin errors++; $display("FAIL cap_swap got %0b want %0b", issue_stall, exp_istall()); end
    if (hazard_stall !== exp_hazard()) begin errors++; $display("FAIL cap_fwd got %0b want %0b", hazard_stall, exp_hazard()); end
    tick();
    idle();
    set_issue(7, 0, 0);
    #1;
    checks++;
    if (issue_stall !== exp_istall()) begin errors++; $display("FAIL cap_still_full got %0b want %0b", issue_stall, exp_istall()); end
    idle();
    foreach (m_int[r]) if (m_int[r]) begin
      set_cmpl(5'(r), 0);
      tick();
    end
    idle();
    #1;
    checks++;
    if (busy !== (m_cnt != 0)) begin errors++; $display("FAIL cap_drain got %0b want %0b", busy, m_cnt != 0); end
  endtask

  task automatic test_wb_slot();
    idle();
    set_issue(10, 0, 3);
    #1;
    checks++;
    if (issue_stall !== exp_istall()) begin errors++; $display("FAIL wb_first got %0b want %0b", issue_stall, exp_istall()); end
    tick();
    set_issue(11, 0, 2);
    #1;
    checks++;
    if (issue_stall !== exp_istall()) begin errors++; $display("FAIL wb_collide got %0b want %0b", issue_stall, exp_istall()); end
    issue_latency = 3;
    #1;
    checks++;
    if (issue_stall !== exp_istall()) begin errors++; $display("FAIL wb_free got %0b want %0b", issue_stall, exp_istall()); end
    tick();
    idle();
    set_cmpl(10, 0);
    tick();
    set_cmpl(11, 0);
    tick();
    idle();
    repeat (8) tick();
  endtask

  task automatic test_same_reg();
    idle();
    set_issue(7, 1, 0);
    tick();
    set_cmpl(7, 1);
    #1;
    checks++;
    if (issue_stall !== exp_istall()) begin errors++; $display("FAIL same_issue got %0b want %0b", issue_stall, exp_istall()); end
    tick();
    idle();
    set_id(7, 1, 0, 0, 0, 0, 0);
    #1;
    checks += 2;
    if (hazard_stall !== exp_hazard()) begin errors++; $display("FAIL same_wins got %0b want %0b", hazard_stall, exp_hazard()); end
    if (busy !== (m_cnt != 0)) begin errors++; $display("FAIL same_busy got %0b want %0b", busy, m_cnt != 0); end
    idle();
    set_cmpl(7, 1);
    tick();
    idle();
    set_cmpl(9, 0);
    tick();
    idle();
    #1;
    checks++;
    if (sb_error !== m_err) begin errors++; $display("FAIL err_set got %0b want %0b", sb_error, m_err); end
    repeat (3) tick();
    checks++;
    if (sb_error !== m_err) begin errors++; $display("FAIL err_sticky got %0b want %0b", sb_error, m_err); end
    set_issue(0, 0, 0);
    tick();
    idle();
    set_id(0, 0, 0, 0, 0, 0, 1);
    #1;
    checks += 2;
    if (hazard_stall !== exp_hazard()) begin errors++; $display("FAIL x0_nostall got %0b want %0b", hazard_stall, exp_hazard()); end
    if (busy !== (m_cnt != 0)) begin errors++; $display("FAIL x0_counted got %0b want %0b", busy, m_cnt != 0); end
    idle();
    set_cmpl(0, 0);
    tick();
    idle();
  endtask

  task automatic test_reset_midflight();
    idle();
    reset_n = 0;
    #1;
    m_clear();
    reset_n = 1;
    tick();
    set_issue(3, 1, 0); tick();
    set_issue(4, 0, 0); tick();
    set_issue(9, 1, 0); tick();
    idle();
    set_cmpl(20, 0);
    tick();
    idle();
    set_id(3, 1, 4, 0, 9, 1, 1);
    #1;
    checks += 2;
    if (hazard_stall !== exp_hazard()) begin errors++; $display("FAIL mid_pre_hazard got %0b want %0b", hazard_stall, exp_hazard()); end
    if (sb_error !== m_err) begin errors++; $display("FAIL mid_pre_err got %0b want %0b", sb_error, m_err); end
    reset_n = 0;
    #1;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b want 0", busy); end
    if (hazard_stall !== 1'b0) begin errors++; $display("FAIL mid_hazard got %0b want 0", hazard_stall); end
    if (sb_error !== 1'b0) begin errors++; $display("FAIL mid_err got %0b want 0", sb_error); end
    m_clear();
    reset_n = 1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      set_issue(5'(i + 10), 0, 0);
      tick();
    end
    set_issue(15, 0, 0);
    #1;
    checks++;
    if (issue_stall !== exp_istall()) begin errors++; $display("FAIL mid_cnt_zero got %0b want %0b", issue_stall, exp_istall()); end
    idle();
    for (int i = 1; i <= 4; i++) begin
      set_cmpl(5'(i + 10), 0);
      tick();
    end
    idle();
  endtask

  task automatic test_random();
    logic [4:0] q_rd[$];
    bit q_fp[$];
    int k;
    bit acc;
    for (int c = 0; c < 400; c++) begin
      idle();
      if (q_rd.size() > 0 && $urandom_range(0, 2) == 0) begin
        k = int'($urandom_range(0, q_rd.size() - 1));
        set_cmpl(q_rd[k], q_fp[k]);
        q_rd.delete(k);
        q_fp.delete(k);
      end
      if ($urandom_range(0, 1) == 1)
        set_issue(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 8)));
      set_id(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rs3_id = 5'($urandom_range(0, 7));
      rs3_used_id = 1'($urandom_range(0, 1));
      #1;
      checks += 4;
      if (issue_stall !== exp_istall()) begin errors++; $display("FAIL rnd_istall c%0d got %0b want %0b", c, issue_stall, exp_istall()); end
      if (hazard_stall !== exp_hazard()) begin errors++; $display("FAIL rnd_hazard c%0d got %0b want %0b", c, hazard_stall, exp_hazard()); end
      if (busy !== (m_cnt != 0)) begin errors++; $display("FAIL rnd_busy c%0d got %0b want %0b", c, busy, m_cnt != 0); end
      if (sb_error !== m_err) begin errors++; $display("FAIL rnd_err c%0d got %0b want %0b", c, sb_error, m_err); end
      acc = issue_valid && !exp_istall();
      if (acc) begin
        q_rd.push_back(issue_rd);
        q_fp.push_back(issue_is_fp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_file_sep();
    test_capacity();
    test_wb_slot();
    test_same_reg();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
